egr_tag_rx: RTL and testbench

Egress tag-ring receiver that sits directly upstream of the Unicast Tag Manager. Each cycle it samples one tag-ring slot and forwards it with one register stage. It claims unicast tags addressed to this EGR's local ports into a show-ahead FIFO, which presents them to the UTM over a valid/ready handshake. Tags it cannot claim because the FIFO is full stay on the ring ("bounce"), so the ring never stalls. Saturating accept and bounce counters give CSR visibility.

---
 rtl/egr_tag_rx.sv | 133 +++++++++++++
 tb/tb_egr_tag_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/egr_tag_rx.sv
// Egress tag-ring receiver: one-stage ring pass-through that claims local unicast
// tags into a show-ahead FIFO for the UTM, bouncing them back onto the ring when full.
module egr_tag_rx #(
    parameter int unsigned PORT_W = 5,
    parameter int unsigned TAG_W  = 64,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      ring_in_valid,
    input  logic                      ring_in_uc,
    input  logic [PORT_W-1:0]         ring_in_port,
    input  logic [TAG_W-1:0]          ring_in_tag,

    output logic                      ring_out_valid,
    output logic                      ring_out_uc,
    output logic [PORT_W-1:0]         ring_out_port,
    output logic [TAG_W-1:0]          ring_out_tag,

    input  logic                      cfg_enable,
    input  logic [(2**PORT_W)-1:0]    cfg_port_mask,

    output logic                      utm_tag_valid,
    input  logic                      utm_tag_ready,
    output logic [PORT_W-1:0]         utm_tag_port,
    output logic [TAG_W-1:0]          utm_tag_data,

    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [CNT_W-1:0]          cnt_accept,
    output logic [CNT_W-1:0]          cnt_bounce,
    input  logic                      cnt_clr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    logic               match;
    logic               full;
    logic               claim;
    logic               pop;
    logic               bounce;
    logic [LVL_W-1:0]   level_nxt;

    // Claim decision: fullness judged on the registered level only.
    always_comb begin
        match     = ring_in_valid & ring_in_uc & cfg_enable & cfg_port_mask[ring_in_port];
        full      = (fifo_level == LVL_W'(DEPTH));
        claim     = match & ~full;
        bounce    = match & full;
        pop       = (fifo_level != '0) & utm_tag_ready;
        level_nxt = fifo_level;
        case ({claim, pop})
            2'b10:   level_nxt = fifo_level + LVL_W'(1);
            2'b01:   level_nxt = fifo_level - LVL_W'(1);
            default: level_nxt = fifo_level;
        endcase
    end

    // Ring stage: claimed slots leave an empty slot; payload fields hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ring_out_valid <= 1'b0;
            ring_out_uc    <= 1'b0;
            ring_out_port  <= '0;
            ring_out_tag   <= '0;
        end else begin
            ring_out_valid <= ring_in_valid & ~claim;
            if (ring_in_valid) begin
                ring_out_uc   <= ring_in_uc;
                ring_out_port <= ring_in_port;
                ring_out_tag  <= ring_in_tag;
            end
        end
    end

    // Storage array carries no reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (claim) begin
            mem[wr_ptr] <= '{port: ring_in_port, tag: ring_in_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (claim) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_level <= level_nxt;
        end
    end

    always_comb begin
        head          = mem[rd_ptr];
        utm_tag_valid = (fifo_level != '0);
        utm_tag_port  = utm_tag_valid ? head.port : '0;
        utm_tag_data  = utm_tag_valid ? head.tag  : '0;
    end

    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            cnt_accept <= '0;
            cnt_bounce <= '0;
        end else begin
            if (claim && (cnt_accept != {CNT_W{1'b1}})) begin
                cnt_accept <= cnt_accept + CNT_W'(1);
            end
            if (bounce && (cnt_bounce != {CNT_W{1'b1}})) begin
                cnt_bounce <= cnt_bounce + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_egr_tag_rx.sv
// Directed plus randomized bench for egr_tag_rx against a queue-based reference model.
module tb_egr_tag_rx;

    localparam int unsigned PORT_W = 5;
    localparam int unsigned TAG_W  = 64;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int          SAT    = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   ring_in_valid;
    logic                   ring_in_uc;
    logic [PORT_W-1:0]      ring_in_port;
    logic [TAG_W-1:0]       ring_in_tag;
    logic                   ring_out_valid;
    logic                   ring_out_uc;
    logic [PORT_W-1:0]      ring_out_port;
    logic [TAG_W-1:0]       ring_out_tag;
    logic                   cfg_enable;
    logic [31:0]            cfg_port_mask;
    logic                   utm_tag_valid;
    logic                   utm_tag_ready;
    logic [PORT_W-1:0]      utm_tag_port;
    logic [TAG_W-1:0]       utm_tag_data;
    logic [4:0]             fifo_level;
    logic [CNT_W-1:0]       cnt_accept;
    logic [CNT_W-1:0]       cnt_bounce;
    logic                   cnt_clr;

    egr_tag_rx #(.PORT_W(PORT_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ring_in_valid(ring_in_valid), .ring_in_uc(ring_in_uc),
        .ring_in_port(ring_in_port), .ring_in_tag(ring_in_tag),
        .ring_out_valid(ring_out_valid), .ring_out_uc(ring_out_uc),
        .ring_out_port(ring_out_port), .ring_out_tag(ring_out_tag),
        .cfg_enable(cfg_enable), .cfg_port_mask(cfg_port_mask),
        .utm_tag_valid(utm_tag_valid), .utm_tag_ready(utm_tag_ready),
        .utm_tag_port(utm_tag_port), .utm_tag_data(utm_tag_data),
        .fifo_level(fifo_level), .cnt_accept(cnt_accept), .cnt_bounce(cnt_bounce),
        .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [TAG_W-1:0]  tag;
    } ent_t;

    // Reference model state
    ent_t               q[$];
    int                 m_acc;
    int                 m_bnc;
    logic               m_rv;
    logic               m_uc;
    logic [PORT_W-1:0]  m_port;
    logic [TAG_W-1:0]   m_tag;
    bit                 m_known;

    int tests = 0;
    int fails = 0;
    logic [TAG_W-1:0] tags [20];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit match, full, claim;
        if (!rst_n) begin
            q.delete();
            m_acc = 0; m_bnc = 0;
            m_rv = 1'b0; m_uc = 1'b0; m_port = '0; m_tag = '0;
            m_known = 1'b1;
        end else begin
            match = ring_in_valid && ring_in_uc && cfg_enable && cfg_port_mask[ring_in_port];
            full  = (q.size() == DEPTH);
            claim = match && !full;
            if (q.size() != 0 && utm_tag_ready) void'(q.pop_front());
            if (claim) q.push_back('{port: ring_in_port, tag: ring_in_tag});
            m_rv = ring_in_valid && !claim;
            if (ring_in_valid) begin
                m_uc = ring_in_uc; m_port = ring_in_port; m_tag = ring_in_tag;
                m_known = !claim;
            end
            if (cnt_clr) begin
                m_acc = 0; m_bnc = 0;
            end else begin
                if (claim && m_acc < SAT) m_acc++;
                if (match && full && m_bnc < SAT) m_bnc++;
            end
        end
    endtask

    task automatic check_all();
        chk("ring_out_valid", 64'(ring_out_valid), 64'(m_rv));
        if (m_known) begin
            chk("ring_out_uc", 64'(ring_out_uc), 64'(m_uc));
            chk("ring_out_port", 64'(ring_out_port), 64'(m_port));
            chk("ring_out_tag", ring_out_tag, m_tag);
        end
        chk("fifo_level", 64'(fifo_level), 64'(q.size()));
        chk("utm_tag_valid", 64'(utm_tag_valid), 64'(q.size() != 0));
        chk("utm_tag_port", 64'(utm_tag_port), (q.size() != 0) ? 64'(q[0].port) : 64'd0);
        chk("utm_tag_data", utm_tag_data, (q.size() != 0) ? q[0].tag : 64'd0);
        chk("cnt_accept", 64'(cnt_accept), 64'(m_acc));
        chk("cnt_bounce", 64'(cnt_bounce), 64'(m_bnc));
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic slot(input logic v, input logic uc, input logic [PORT_W-1:0] p,
                        input logic [TAG_W-1:0] t);
        ring_in_valid = v; ring_in_uc = uc; ring_in_port = p; ring_in_tag = t;
    endtask

    task automatic idle();
        slot(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        rst_n = 1'b0; idle(); cfg_enable = 1'b0; cfg_port_mask = '0;
        utm_tag_ready = 1'b0; cnt_clr = 1'b0;
        cyc(); cyc();
        chk("reset ring_out_valid", 64'(ring_out_valid), 64'd0);
        chk("reset ring_out_tag", ring_out_tag, 64'd0);
        chk("reset fifo_level", 64'(fifo_level), 64'd0);
        chk("reset cnt_accept", 64'(cnt_accept), 64'd0);
        rst_n = 1'b1;

        // Single claim
        cfg_port_mask = 32'h1; cfg_enable = 1'b1;
        slot(1'b1, 1'b1, 5'd0, 64'hA5);
        cyc();
        chk("single ring_out_valid", 64'(ring_out_valid), 64'd0);
        chk("single utm_tag_valid", 64'(utm_tag_valid), 64'd1);
        chk("single utm_tag_data", utm_tag_data, 64'hA5);
        chk("single cnt_accept", 64'(cnt_accept), 64'd1);
        idle(); utm_tag_ready = 1'b1; cyc();
        utm_tag_ready = 1'b0; cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;

        // Pass-through: non-local port, multicast, disabled
        slot(1'b1, 1'b1, 5'd3, 64'h1111_0003); cyc();
        chk("pass nonlocal valid", 64'(ring_out_valid), 64'd1);
        chk("pass nonlocal tag", ring_out_tag, 64'h1111_0003);
        slot(1'b1, 1'b0, 5'd0, 64'h2222_0000); cyc();
        chk("pass mc valid", 64'(ring_out_valid), 64'd1);
        chk("pass mc uc", 64'(ring_out_uc), 64'd0);
        cfg_enable = 1'b0;
        slot(1'b1, 1'b1, 5'd0, 64'h3333_0000); cyc();
        chk("pass disabled tag", ring_out_tag, 64'h3333_0000);
        chk("pass fifo_level", 64'(fifo_level), 64'd0);
        chk("pass cnt_accept", 64'(cnt_accept), 64'd0);
        cfg_enable = 1'b1;

        // Full / bounce with the UTM stalled
        for (int i = 0; i < 20; i++) begin
            tags[i] = {$urandom, $urandom};
            slot(1'b1, 1'b1, 5'd0, tags[i]);
            cyc();
            chk("full ring_out_valid", 64'(ring_out_valid), (i >= 16) ? 64'd1 : 64'd0);
        end
        idle(); cyc();
        chk("full fifo_level", 64'(fifo_level), 64'd16);
        chk("full cnt_bounce", 64'(cnt_bounce), 64'd4);
        utm_tag_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain order", utm_tag_data, tags[i]);
            cyc();
        end
        chk("drain empty", 64'(utm_tag_valid), 64'd0);

        // Simultaneous push and pop while full: arrival still bounces
        utm_tag_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            slot(1'b1, 1'b1, 5'd0, 64'(i + 100)); cyc();
        end
        utm_tag_ready = 1'b1;
        slot(1'b1, 1'b1, 5'd0, 64'hDEAD); cyc();
        chk("pushpop ring_out_valid", 64'(ring_out_valid), 64'd1);
        chk("pushpop fifo_level", 64'(fifo_level), 64'd15);
        idle();
        for (int i = 0; i < 15; i++) cyc();

        // Counter saturation and clear priority
        cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            slot(1'b1, 1'b1, 5'd0, 64'(i)); cyc();
        end
        chk("sat cnt_accept", 64'(cnt_accept), 64'(SAT));
        cnt_clr = 1'b1; slot(1'b1, 1'b1, 5'd0, 64'h77); cyc(); cnt_clr = 1'b0;
        chk("clr cnt_accept", 64'(cnt_accept), 64'd0);
        idle(); cyc(); cyc();

        // Mid-traffic reset
        utm_tag_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            slot(1'b1, 1'b1, 5'd0, 64'(i + 500)); cyc();
        end
        chk("pre-reset level", 64'(fifo_level), 64'd5);
        slot(1'b1, 1'b1, 5'd0, 64'h600); rst_n = 1'b0; cyc();
        chk("midrst fifo_level", 64'(fifo_level), 64'd0);
        chk("midrst utm_tag_valid", 64'(utm_tag_valid), 64'd0);
        chk("midrst ring_out_valid", 64'(ring_out_valid), 64'd0);
        chk("midrst cnt_accept", 64'(cnt_accept), 64'd0);
        rst_n = 1'b1; slot(1'b1, 1'b1, 5'd0, 64'h601); cyc();
        chk("post-reset claim level", 64'(fifo_level), 64'd1);
        chk("post-reset claim data", utm_tag_data, 64'h601);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 0) cfg_port_mask = $urandom;
            cfg_enable    = ($urandom % 8) != 0;
            slot(($urandom % 5) != 0, ($urandom % 4) != 0, PORT_W'($urandom), {$urandom, $urandom});
            utm_tag_ready = ((i / 64) % 2 == 0) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            cnt_clr       = ($urandom % 50) == 0;
            rst_n         = ($urandom % 300) != 0;
            cyc();
        end
        rst_n = 1'b1; cnt_clr = 1'b0; idle(); cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
